sdram_burst_writer: RTL

- Write-side master feeding the SDRAM command arbiter's writer interface.
- Accepts a pixel/word stream, buffers it, and issues one write command per BURST_LEN buffered words.
- Addresses increment linearly inside a ring region; start-of-frame rewinds the address to the region base.
- Command payload carries no write data; the controller pulls burst data from this block's FWFT data port after the command is accepted.

---
 rtl/sdram_burst_writer_pkg.sv | 14 +
 rtl/sdram_sync_fifo.sv | 62 ++++++
 rtl/sdram_burst_writer.sv | 95 +++++++++
 3 files changed

// File: rtl/sdram_burst_writer_pkg.sv
// Shared helpers for the SDRAM burst writer/reader pair.
package sdram_burst_writer_pkg;

    // Advance a burst start address inside a ring region, wrapping to its base.
    function automatic int unsigned ring_next(
        input int unsigned addr,
        input int unsigned step,
        input int unsigned base,
        input int unsigned words
    );
        return (addr + step == base + words) ? base : addr + step;
    endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout holds the last popped word while empty.
module sdram_sync_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign count   = cnt;
    assign dout    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sdram_burst_writer.sv
// Buffers a word stream and issues one SDRAM write command per BURST_LEN words;
// the controller pulls burst data from the FWFT port after each accepted command.
module sdram_burst_writer
    import sdram_burst_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned REGION_WORDS = 2**19
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_sof,
    output logic                          writer_valid,
    input  logic                          writer_ready,
    output logic [ADDR_WIDTH-1:0]         writer_addr,
    input  logic                          wdata_rd_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          align_err,
    output logic                          underflow_err,
    output logic [$clog2(FIFO_DEPTH):0]   buf_level
);
    localparam int unsigned    LW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]  BURST = LW'(BURST_LEN);

    logic [LW-1:0]         pending_words;
    logic [LW-1:0]         committed;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  run_q;
    logic                  fifo_full;
    logic                  accept;
    logic                  handshake;
    logic                  pop_ok;

    // A SOF word waits until every complete burst has been handed to the arbiter,
    // so the address rewind can never race a command handshake.
    assign s_ready      = run_q && !fifo_full && !(s_sof && (pending_words >= BURST));
    assign writer_valid = (pending_words >= BURST);
    assign writer_addr  = addr_reg;
    assign accept       = s_valid && s_ready;
    assign handshake    = writer_valid && writer_ready;
    assign committed    = buf_level - pending_words;
    assign pop_ok       = wdata_rd_en && (committed != '0);
    assign addr_next    = ADDR_WIDTH'(ring_next(32'(addr_reg), BURST_LEN, BASE_ADDR, REGION_WORDS));

    sdram_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_data_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (accept),
        .din   (s_data),
        .rd_en (pop_ok),
        .dout  (wdata),
        .full  (fifo_full),
        .count (buf_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q         <= 1'b0;
            pending_words <= '0;
            addr_reg      <= ADDR_WIDTH'(BASE_ADDR);
            align_err     <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case ({accept, handshake})
                2'b10:   pending_words <= pending_words + 1'b1;
                2'b01:   pending_words <= pending_words - BURST;
                2'b11:   pending_words <= pending_words + 1'b1 - BURST;
                default: pending_words <= pending_words;
            endcase
            if (handshake) begin
                addr_reg <= addr_next;
            end else if (accept && s_sof) begin
                addr_reg <= ADDR_WIDTH'(BASE_ADDR);
            end
            if (accept && s_sof && (pending_words != '0)) begin
                align_err <= 1'b1;
            end
            if (wdata_rd_en && (committed == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
